// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the MIPS HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over WIDTH cycles, then one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0; the accepting edge raises busy,
  // and done pulses for one cycle in the cycle after the FIX edge, when busy drops.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_orig;
  logic               sign_q;
  logic               sign_r;
  logic               b_zero;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic accept;
  logic op_is_div;
  logic op_signed;
  logic new_signed;

  assign accept     = (state == S_IDLE) && start;
  assign op_is_div  = op_q[1];
  assign op_signed  = ~op_q[0];
  assign new_signed = ~op[0];
  assign dbg_state  = state;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    magnitude = (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == CNT_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // One iteration step. Multiply adds into the upper half with carry kept in a
  // 33-bit sum; divide shifts the next dividend bit into the remainder and trial-subtracts.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    trial   = rem_sh - {1'b0, mag_b};
    if (op_is_div)
      acc_step = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                  acc[WIDTH-2:0], ~trial[WIDTH]};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction and final HI/LO selection for the FIX edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  always_comb begin
    prod_fix = (op_signed && sign_q) ? (~acc + 1'b1) : acc;
    quot_fix = (op_signed && sign_q) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = (op_signed && sign_r) ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    if (!op_is_div) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (b_zero) begin
      hi_res = a_orig;
      lo_res = '1;
    end else begin
      hi_res = rem_fix;
      lo_res = quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_orig   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      b_zero   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op;
            mag_a  <= magnitude(a, new_signed);
            mag_b  <= magnitude(b, new_signed);
            a_orig <= a;
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            b_zero <= (b == '0);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (op_is_div) mag_a <= {mag_a[WIDTH-2:0], 1'b0};
          else           mag_b <= {1'b0, mag_b[WIDTH-1:1]};
        end
        S_FIX: begin
          hi       <= hi_res;
          lo       <= lo_res;
          done     <= 1'b1;
          div_zero <= op_is_div && b_zero;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference model feeds an expected queue,
// a done-monitor pops and compares; latency, handshake, MTHI/MTLO and reset-abort checked inline.
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // {div_zero, hi, lo}
  logic [64:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] m_op, input logic [31:0] m_a,
                                        input logic [31:0] m_b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    if (m_op == 2'd0) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (m_op == 2'd1) begin
      p = {32'b0, m_a} * {32'b0, m_b};
      return {1'b0, p};
    end
    if (m_b == 32'd0) return {1'b1, m_a, 32'hFFFF_FFFF};
    if (m_op == 2'd2) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = m_a / m_b;
      r = m_a % m_b;
    end
    return {1'b0, r, q};
  endfunction

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    logic [64:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_hi", {32'b0, hi}, {32'b0, e[63:32]});
        check("sb_lo", {32'b0, lo}, {32'b0, e[31:0]});
        check("sb_div_zero", {63'b0, div_zero}, {63'b0, e[64]});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // mode 0: plain; 1: MTHI/MTLO and a second start during busy; 2: hi_we/lo_we alongside start
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input int mode);
    int lat;
    int busy_cnt;
    @(negedge clk);
    exp_q.push_back(model(t_op, t_a, t_b));
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    if (mode == 2) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (mode == 1 && lat >= 3 && lat < 6) begin
        start = 1'b1;
        op    = ~t_op;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_5A5A;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("latency", 64'(lat), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_at_done", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    op      = 2'd0;
    a       = '0;
    b       = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;
    do_reset();

    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_div_zero", {63'b0, div_zero}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);

    // directed cases, also pinned to literal results
    run_op(2'd0, 32'hFFFF_FFFF, 32'd7, 0);
    check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'b0, lo}, 64'hFFFF_FFF9);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'b0, lo}, 64'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mult_m1_hi", {32'b0, hi}, 64'd0);
    check("mult_m1_lo", {32'b0, lo}, 64'd1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    run_op(2'd3, 32'd100, 32'd7, 0);
    check("divu_lo", {32'b0, lo}, 64'd14);
    check("divu_hi", {32'b0, hi}, 64'd2);
    run_op(2'd3, 32'h64, 32'd0, 0);
    check("dz_hi", {32'b0, hi}, 64'h64);
    check("dz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
    check("dz_flag", {63'b0, div_zero}, 64'd1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo", {32'b0, lo}, 64'h8000_0000);
    check("ovf_hi", {32'b0, hi}, 64'd0);
    check("ovf_dz", {63'b0, div_zero}, 64'd0);
    run_op(2'd2, 32'h8000_0000, 32'd0, 0);

    // MTHI/MTLO in idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mt_hi", {32'b0, hi}, 64'h1234_5678);
    check("mt_lo", {32'b0, lo}, 64'h1234_5678);
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_only_hi", {32'b0, hi}, 64'h0BAD_F00D);
    check("mthi_only_lo", {32'b0, lo}, 64'h1234_5678);

    // writes and a second start during busy are ignored; start beats MTHI/MTLO
    run_op(2'd1, 32'h0001_0003, 32'h0002_0005, 1);
    repeat (40) @(posedge clk);
    check("busy_ignored_hi", {32'b0, hi}, 64'h0000_0002);
    check("busy_ignored_lo", {32'b0, lo}, 64'h000B_000F);
    run_op(2'd3, 32'd55, 32'd6, 2);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    a     = 32'hCAFE_0001;
    b     = 32'h0000_1234;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    check("abort_state", {62'b0, dbg_state}, 64'd0);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    run_op(2'd1, 32'h0000_FFFF, 32'h0001_0001, 0);

    // random back-to-back operations
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 9));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 0);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
